// File: rtl/dbg_pkg.sv
// Shared definitions for the Risc32 debug/load responder: opcodes, FSM states, field widths.
// Opcode legality depends on DBG_BREAKPOINT_EN (enables OP_SET_BP).
package dbg_pkg;

    localparam int DATA_W    = 32;
    localparam int OP_W      = 4;
    localparam int REG_IDX_W = 5;

    localparam logic [OP_W-1:0] OP_RD_REG  = 4'd0;
    localparam logic [OP_W-1:0] OP_WR_IMEM = 4'd1;
    localparam logic [OP_W-1:0] OP_WR_DMEM = 4'd2;
    localparam logic [OP_W-1:0] OP_RD_DMEM = 4'd3;
    localparam logic [OP_W-1:0] OP_SET_PC  = 4'd4;
    localparam logic [OP_W-1:0] OP_STEP    = 4'd5;
    localparam logic [OP_W-1:0] OP_RUN     = 4'd6;
    localparam logic [OP_W-1:0] OP_HALT    = 4'd7;
    localparam logic [OP_W-1:0] OP_SET_BP  = 4'd8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RD_WAIT,
        ST_STEPPING,
        ST_RUNNING,
        ST_RESP
    } state_t;

    function automatic logic op_defined(input logic [OP_W-1:0] op);
`ifdef DBG_BREAKPOINT_EN
        return (op <= OP_SET_BP);
`else
        return (op <= OP_HALT);
`endif
    endfunction

    // While the core free-runs only commands that cannot disturb it are honoured.
    function automatic logic op_legal(input logic [OP_W-1:0] op, input logic running);
        logic ok;
        ok = op_defined(op);
        if (running) begin
`ifdef DBG_BREAKPOINT_EN
            ok = ok && (op == OP_HALT || op == OP_SET_BP);
`else
            ok = ok && (op == OP_HALT);
`endif
        end
        return ok;
    endfunction

endpackage

// File: rtl/dbg_cmd_responder_step_counter.sv
// Core clock-enable generator: loadable down-counter for STEP, free-run mode for RUN,
// immediate halt, and an abort input used by the breakpoint logic.
module dbg_step_counter #(
    parameter int STEP_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              step_load,
    input  logic [STEP_W-1:0] step_count,
    input  logic              run_start,
    input  logic              halt,
    input  logic              abort,
    output logic              cpu_run,
    output logic              active,
    output logic              run_mode,
    output logic              done
);

    logic [STEP_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active   <= 1'b0;
            run_mode <= 1'b0;
            count    <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (halt) begin
                active   <= 1'b0;
                run_mode <= 1'b0;
                count    <= '0;
            end else if (abort && active) begin
                active   <= 1'b0;
                run_mode <= 1'b0;
                count    <= '0;
                done     <= 1'b1;
            end else if (step_load) begin
                count    <= step_count;
                run_mode <= 1'b0;
                if (step_count == '0) begin
                    done <= 1'b1;
                end else begin
                    active <= 1'b1;
                end
            end else if (run_start) begin
                active   <= 1'b1;
                run_mode <= 1'b1;
            end else if (active && !run_mode) begin
                count <= count - STEP_W'(1);
                if (count == STEP_W'(1)) begin
                    active <= 1'b0;
                    done   <= 1'b1;
                end
            end
        end
    end

    // Abort gates the enable in the same cycle so the breakpoint instruction never retires.
    assign cpu_run = active && !abort;

endmodule

// File: rtl/dbg_cmd_responder.sv
// Debug/load responder for the Risc32 core: valid/ready command link driving memory,
// register-file and PC debug ports plus the core clock-enable. Optional macro: DBG_BREAKPOINT_EN.
module dbg_cmd_responder
    import dbg_pkg::*;
#(
    parameter int IMEM_ROWS = 16,
    parameter int DMEM_ROWS = 32,
    parameter int STEP_W    = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [OP_W-1:0]              cmd_op,
    input  logic [DATA_W-1:0]            cmd_addr,
    input  logic [DATA_W-1:0]            cmd_data,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [DATA_W-1:0]            rsp_data,
    output logic                         rsp_err,
    output logic                         cpu_run,
    input  logic [DATA_W-1:0]            pc_current,
    output logic                         pc_load,
    output logic [DATA_W-1:0]            pc_value,
    output logic                         imem_we,
    output logic [$clog2(IMEM_ROWS)-1:0] imem_addr,
    output logic                         dmem_we,
    output logic [$clog2(DMEM_ROWS)-1:0] dmem_addr,
    output logic [DATA_W-1:0]            mem_wdata,
    input  logic [DATA_W-1:0]            dmem_rdata,
    output logic [REG_IDX_W-1:0]         reg_raddr,
    input  logic [DATA_W-1:0]            reg_rdata
);

    localparam int IMEM_AW = $clog2(IMEM_ROWS);
    localparam int DMEM_AW = $clog2(DMEM_ROWS);
    localparam int ADDR_HI = ((IMEM_AW > DMEM_AW) ? IMEM_AW : DMEM_AW) + 1;

    state_t            state;
    logic [OP_W-1:0]   op_q;
    logic              err_q;
    logic [STEP_W-1:0] step_q;
    logic              step_load;
    logic              run_start;
    logic              accept;
    logic              halt_req;
    logic              cmd_legal;
    logic              core_active;
    logic              core_running;
    logic              step_done;
    logic              bp_hit;
    logic              bp_pending;
    logic              unused_addr_bits;

`ifdef DBG_BREAKPOINT_EN
    logic              bp_valid;
    logic [DATA_W-1:0] bp_pc;
    assign bp_hit = bp_valid && core_active && (pc_current == bp_pc);
`else
    assign bp_hit     = 1'b0;
    assign bp_pending = 1'b0;
`endif

    assign unused_addr_bits = ^{cmd_addr[DATA_W-1:ADDR_HI+1], core_active};

    // A queued breakpoint report must go out before the next command is taken.
    assign cmd_ready = (state == ST_IDLE || state == ST_RUNNING) && !bp_pending;
    assign accept    = cmd_valid && cmd_ready;
    assign cmd_legal = op_legal(cmd_op, core_running);
    assign halt_req  = accept && (cmd_op == OP_HALT);

    dbg_step_counter #(
        .STEP_W(STEP_W)
    ) u_step_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .step_load (step_load),
        .step_count(step_q),
        .run_start (run_start),
        .halt      (halt_req),
        .abort     (bp_hit),
        .cpu_run   (cpu_run),
        .active    (core_active),
        .run_mode  (core_running),
        .done      (step_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            op_q      <= '0;
            err_q     <= 1'b0;
            step_q    <= '0;
            step_load <= 1'b0;
            run_start <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
            pc_load   <= 1'b0;
            pc_value  <= '0;
            imem_we   <= 1'b0;
            imem_addr <= '0;
            dmem_we   <= 1'b0;
            dmem_addr <= '0;
            mem_wdata <= '0;
            reg_raddr <= '0;
`ifdef DBG_BREAKPOINT_EN
            bp_valid   <= 1'b0;
            bp_pc      <= '0;
            bp_pending <= 1'b0;
`endif
        end else begin
            imem_we   <= 1'b0;
            dmem_we   <= 1'b0;
            pc_load   <= 1'b0;
            step_load <= 1'b0;
            run_start <= 1'b0;
`ifdef DBG_BREAKPOINT_EN
            if (bp_hit && core_running) begin
                bp_pending <= 1'b1;
            end
`endif
            case (state)
                ST_IDLE, ST_RUNNING: begin
`ifdef DBG_BREAKPOINT_EN
                    if (bp_pending) begin
                        rsp_data   <= bp_pc;
                        rsp_err    <= 1'b0;
                        rsp_valid  <= 1'b1;
                        bp_pending <= 1'b0;
                        state      <= ST_RESP;
                    end else
`endif
                    if (accept) begin
                        op_q      <= cmd_op;
                        err_q     <= !cmd_legal;
                        step_q    <= cmd_data[STEP_W-1:0];
                        pc_value  <= cmd_data;
                        mem_wdata <= cmd_data;
                        imem_addr <= cmd_addr[IMEM_AW+1:2];
                        dmem_addr <= cmd_addr[DMEM_AW+1:2];
                        reg_raddr <= cmd_addr[REG_IDX_W-1:0];
                        imem_we   <= cmd_legal && (cmd_op == OP_WR_IMEM);
                        dmem_we   <= cmd_legal && (cmd_op == OP_WR_DMEM);
                        pc_load   <= cmd_legal && (cmd_op == OP_SET_PC);
                        step_load <= cmd_legal && (cmd_op == OP_STEP);
                        run_start <= cmd_legal && (cmd_op == OP_RUN);
`ifdef DBG_BREAKPOINT_EN
                        if (cmd_legal && cmd_op == OP_SET_BP) begin
                            bp_pc    <= cmd_data;
                            bp_valid <= 1'b1;
                        end
`endif
                        state <= ST_EXEC;
                    end
                end

                ST_EXEC: begin
                    if (err_q) begin
                        rsp_data  <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end else begin
                        case (op_q)
                            OP_RD_REG: begin
                                rsp_data  <= reg_rdata;
                                rsp_valid <= 1'b1;
                                state     <= ST_RESP;
                            end
                            OP_RD_DMEM: state <= ST_RD_WAIT;
                            OP_STEP:    state <= ST_STEPPING;
                            OP_RUN, OP_HALT: begin
                                rsp_data  <= pc_current;
                                rsp_valid <= 1'b1;
                                state     <= ST_RESP;
                            end
                            default: begin
                                rsp_data  <= '0;
                                rsp_valid <= 1'b1;
                                state     <= ST_RESP;
                            end
                        endcase
                    end
                end

                ST_RD_WAIT: begin
                    rsp_data  <= dmem_rdata;
                    rsp_valid <= 1'b1;
                    state     <= ST_RESP;
                end

                // The done pulse arrives once the final retired instruction has updated the PC.
                ST_STEPPING: begin
                    if (step_done) begin
                        rsp_data  <= pc_current;
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end
                end

                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        state     <= core_running ? ST_RUNNING : ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dbg_cmd_responder.sv
// Self-checking bench for dbg_cmd_responder with a tiny behavioural Risc32 core model.
// Default build assumes DBG_BREAKPOINT_EN undefined; opcode 8 expectation follows the macro.
module tb_dbg_cmd_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_op = '0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_data = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        cpu_run;
    logic [31:0] pc_current;
    logic        pc_load;
    logic [31:0] pc_value;
    logic        imem_we;
    logic [3:0]  imem_addr;
    logic        dmem_we;
    logic [4:0]  dmem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] dmem_rdata;
    logic [4:0]  reg_raddr;
    logic [31:0] reg_rdata;

    always #5 clk = ~clk;

    dbg_cmd_responder #(.IMEM_ROWS(16), .DMEM_ROWS(32), .STEP_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .cpu_run(cpu_run), .pc_current(pc_current), .pc_load(pc_load), .pc_value(pc_value),
        .imem_we(imem_we), .imem_addr(imem_addr), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .mem_wdata(mem_wdata), .dmem_rdata(dmem_rdata),
        .reg_raddr(reg_raddr), .reg_rdata(reg_rdata)
    );

    // Core model: memories, PC and register file; loads (opcode 03) read a full data word.
    logic [31:0] imem [16];
    logic [31:0] dmem [32];
    logic [31:0] regs [32];
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] ld_addr;

    assign pc_current = pc;
    assign reg_rdata  = regs[reg_raddr];
    assign instr      = imem[pc[5:2]];
    assign ld_addr    = regs[instr[19:15]] + {{20{instr[31]}}, instr[31:20]};

    initial begin
        for (int i = 0; i < 16; i++) imem[i] = '0;
        for (int i = 0; i < 32; i++) dmem[i] = '0;
        for (int i = 0; i < 32; i++) regs[i] = '0;
        regs[2]    = 32'd4;
        pc         = '0;
        dmem_rdata = '0;
    end

    always @(posedge clk) begin
        if (imem_we) imem[imem_addr] <= mem_wdata;
        if (dmem_we) dmem[dmem_addr] <= mem_wdata;
        dmem_rdata <= dmem[dmem_addr];
        if (pc_load) begin
            pc <= pc_value;
        end else if (cpu_run) begin
            pc <= pc + 32'd4;
            if (instr[6:0] == 7'h03 && instr[11:7] != 5'd0)
                regs[instr[11:7]] <= dmem[ld_addr[6:2]];
        end
    end

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_imem;
        int          exp_dmem;
        int          exp_pcl;
        int          exp_run;
        int          exp_idx;
        string       name;
    } vec_t;

    vec_t vecs [16];

    int          n_checks = 0;
    int          n_fail = 0;
    int          n_imem, n_dmem, n_pcl, n_run, got_idx;
    logic [31:0] got_data;
    logic        got_err;
    logic        got_ok;
    logic        accepted;
    logic [3:0]  last_op;

    function automatic vec_t mk(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data,
                                input logic [31:0] ed, input logic ee, input int ei, input int edm,
                                input int ep, input int er, input int ex, input string nm);
        vec_t v;
        v.op = op; v.addr = addr; v.data = data; v.exp_data = ed; v.exp_err = ee;
        v.exp_imem = ei; v.exp_dmem = edm; v.exp_pcl = ep; v.exp_run = er; v.exp_idx = ex; v.name = nm;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic sendCmd(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data);
        cmd_op = op; cmd_addr = addr; cmd_data = data; cmd_valid = 1'b1;
        last_op = op;
        accepted = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (cmd_ready) begin
                accepted = 1'b1;
                break;
            end
        end
        if (!accepted) checkOutput("accept_timeout", 32'd0, 32'd1);
        else @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic waitRsp(input int budget);
        got_ok = 1'b0; n_imem = 0; n_dmem = 0; n_pcl = 0; n_run = 0; got_idx = -1;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (imem_we) begin n_imem++; got_idx = int'(imem_addr); end
            if (dmem_we) begin n_dmem++; got_idx = int'(dmem_addr); end
            if (pc_load) n_pcl++;
            if (cpu_run) n_run++;
            if (rsp_valid) begin
                got_data = rsp_data;
                got_err  = rsp_err;
                got_ok   = 1'b1;
                if (last_op == 4'd3) got_idx = int'(dmem_addr);
                break;
            end
        end
        if (!got_ok) checkOutput("rsp_timeout", 32'd0, 32'd1);
        else if (rsp_ready) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data);
        sendCmd(op, addr, data);
        waitRsp(100);
    endtask

    logic [31:0] pc_halt;
    int          run_seen;
    int          rsp_seen;

    initial begin
        vecs[0]  = mk(4'd1, 32'd0,   32'h00010083, 32'h0,        1'b0, 1, 0, 0, 0,  0, "wr_imem_0");
        vecs[1]  = mk(4'd2, 32'd4,   32'h00007f7f, 32'h0,        1'b0, 0, 1, 0, 0,  1, "wr_dmem_4");
        vecs[2]  = mk(4'd4, 32'd0,   32'h0,        32'h0,        1'b0, 0, 0, 1, 0, -1, "set_pc_0");
        vecs[3]  = mk(4'd5, 32'd0,   32'd1,        32'h4,        1'b0, 0, 0, 0, 1, -1, "step_1");
        vecs[4]  = mk(4'd0, 32'd1,   32'h0,        32'h00007f7f, 1'b0, 0, 0, 0, 0, -1, "rd_reg_1");
        vecs[5]  = mk(4'd2, 32'd124, 32'h88888888, 32'h0,        1'b0, 0, 1, 0, 0, 31, "wr_dmem_124");
        vecs[6]  = mk(4'd3, 32'd128, 32'h0,        32'h0,        1'b0, 0, 0, 0, 0,  0, "rd_dmem_128_wrap");
        vecs[7]  = mk(4'd3, 32'd124, 32'h0,        32'h88888888, 1'b0, 0, 0, 0, 0, 31, "rd_dmem_124");
        vecs[8]  = mk(4'd7, 32'd0,   32'h0,        32'h4,        1'b0, 0, 0, 0, 0, -1, "halt_idle");
        vecs[9]  = mk(4'd5, 32'd0,   32'd0,        32'h4,        1'b0, 0, 0, 0, 0, -1, "step_0");
        vecs[10] = mk(4'd5, 32'd0,   32'd3,        32'd16,       1'b0, 0, 0, 0, 3, -1, "step_3");
        vecs[11] = mk(4'd0, 32'd2,   32'h0,        32'h4,        1'b0, 0, 0, 0, 0, -1, "rd_reg_2");
        vecs[12] = mk(4'd9, 32'd0,   32'h0,        32'h0,        1'b1, 0, 0, 0, 0, -1, "undef_op9");
`ifdef DBG_BREAKPOINT_EN
        vecs[13] = mk(4'd8, 32'd0,   32'hfffffff0, 32'h0,        1'b0, 0, 0, 0, 0, -1, "set_bp");
`else
        vecs[13] = mk(4'd8, 32'd0,   32'hfffffff0, 32'h0,        1'b1, 0, 0, 0, 0, -1, "op8_disabled");
`endif
        vecs[14] = mk(4'd15, 32'd0,  32'h12345678, 32'h0,        1'b1, 0, 0, 0, 0, -1, "undef_op15");
        vecs[15] = mk(4'd1, 32'd64,  32'h00010083, 32'h0,        1'b0, 1, 0, 0, 0,  0, "wr_imem_64_wrap");

        // Reset state, then five idle cycles.
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkOutput("idle_cpu_run",   {31'd0, cpu_run},   32'd0);
            checkOutput("idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);
            checkOutput("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);
            checkOutput("idle_strobes",   {29'd0, imem_we, dmem_we, pc_load}, 32'd0);
        end
        checkOutput("idle_rsp_data", rsp_data, 32'd0);
        checkOutput("idle_rsp_err",  {31'd0, rsp_err}, 32'd0);

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].op, vecs[i].addr, vecs[i].data);
            checkOutput({vecs[i].name, "_data"}, got_data, vecs[i].exp_data);
            checkOutput({vecs[i].name, "_err"},  {31'd0, got_err}, {31'd0, vecs[i].exp_err});
            checkOutput({vecs[i].name, "_imem_we"}, n_imem, vecs[i].exp_imem);
            checkOutput({vecs[i].name, "_dmem_we"}, n_dmem, vecs[i].exp_dmem);
            checkOutput({vecs[i].name, "_pc_load"}, n_pcl,  vecs[i].exp_pcl);
            checkOutput({vecs[i].name, "_run_cycles"}, n_run, vecs[i].exp_run);
            if (vecs[i].exp_idx >= 0) checkOutput({vecs[i].name, "_index"}, got_idx, vecs[i].exp_idx);
        end

        // RUN with the response held off: data must stay stable while the core runs.
        rsp_ready = 1'b0;
        sendCmd(4'd6, 32'd0, 32'd0);
        waitRsp(20);
        checkOutput("run_ack_data", got_data, 32'd16);
        checkOutput("run_ack_err", {31'd0, got_err}, 32'd0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checkOutput("run_hold_valid", {31'd0, rsp_valid}, 32'd1);
            checkOutput("run_hold_data",  rsp_data, 32'd16);
            checkOutput("run_hold_cpu_run", {31'd0, cpu_run}, 32'd1);
            checkOutput("run_hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus(4'd1, 32'd8, 32'hdeadbeef);
        checkOutput("run_wr_imem_err", {31'd0, got_err}, 32'd1);
        checkOutput("run_wr_imem_we",  n_imem, 32'd0);
        checkOutput("run_still_running", {31'd0, cpu_run}, 32'd1);

        sendCmd(4'd7, 32'd0, 32'd0);
        pc_halt = pc;
        @(negedge clk);
        checkOutput("halt_cpu_run_drop", {31'd0, cpu_run}, 32'd0);
        waitRsp(20);
        checkOutput("halt_ack_pc",  got_data, pc_halt);
        checkOutput("halt_ack_err", {31'd0, got_err}, 32'd0);
        checkOutput("halt_pc_frozen", pc, pc_halt);
        checkOutput("halt_imem_untouched", imem[2], 32'd0);

        // STEP 10 interrupted by reset after the fourth enabled cycle.
        sendCmd(4'd5, 32'd0, 32'd10);
        run_seen = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (cpu_run) run_seen++;
            if (run_seen == 4) break;
        end
        checkOutput("step10_reached_4", run_seen, 32'd4);
        rst_n = 1'b0;
        #1;
        checkOutput("reset_cpu_run", {31'd0, cpu_run}, 32'd0);
        checkOutput("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rsp_seen = 0;
        run_seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (rsp_valid) rsp_seen++;
            if (cpu_run) run_seen++;
        end
        checkOutput("post_reset_no_rsp", rsp_seen, 32'd0);
        checkOutput("post_reset_no_run", run_seen, 32'd0);

        applyStimulus(4'd0, 32'd1, 32'd0);
        checkOutput("post_reset_rd_reg", got_data, 32'h00007f7f);
        checkOutput("post_reset_rd_err", {31'd0, got_err}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got running expected finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
